// File: rtl/srs_receiver_fsm.sv
// srs_receiver_fsm: receiving end of the RTS/ACK serial link.
// Grants the transmitter's request-to-send, shifts in one frame on the
// transmitter's bit strobe, and holds the word in a one-entry valid/ready
// buffer. err pulses for one cycle on an aborted frame or a parity failure.
// Optional feature: define SRS_RX_PARITY_EN for an even-parity bit after the
// data bits (WIDTH+1 strobes per frame).
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | ack=0, waiting for rts with the buffer free
// RECV  | ack=1, counting strobes and shifting in bits
// DONE  | ack=1, frame finished, waiting for rts low

module srs_receiver_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rts,
    input  logic             sclk,
    input  logic             sdin,
    input  logic             rready,
    output logic             ack,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 2);

`ifdef SRS_RX_PARITY_EN
    localparam int NSTB = WIDTH + 1;
    localparam int SW   = WIDTH;
`else
    // Without parity the last data bit goes straight from sdin into rdata,
    // so the shift register only ever needs to hold WIDTH-1 bits.
    localparam int NSTB = WIDTH;
    localparam int SW   = WIDTH - 1;
`endif

    localparam logic [CW-1:0] LAST_IDX = CW'(NSTB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    shreg_q, shreg_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;

`ifdef SRS_RX_PARITY_EN
    logic             par_q, par_d;
    logic [SW-1:0]    shift_nxt;
    assign shift_nxt = {shreg_q[SW-2:0], sdin};
`else
    logic [WIDTH-1:0] shift_nxt;
    assign shift_nxt = {shreg_q, sdin};
`endif

    // Next-state, datapath and output-buffer decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        err_d    = 1'b0;
`ifdef SRS_RX_PARITY_EN
        par_d    = par_q;
`endif

        // A pop clears the buffer; a word completing this cycle overrides below.
        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (rts && (!rvalid_q || rready)) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shreg_d = '0;
`ifdef SRS_RX_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            RECV: begin
                if (sclk && (cnt_q == LAST_IDX)) begin
                    // The final strobe wins over a simultaneous rts drop.
`ifdef SRS_RX_PARITY_EN
                    if (sdin == par_q) begin
                        rdata_d  = shreg_q;
                        rvalid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
`else
                    rdata_d  = shift_nxt;
                    rvalid_d = 1'b1;
`endif
                    cnt_d   = cnt_q + CW'(1);
                    state_d = rts ? DONE : IDLE;
                end else if (!rts) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk) begin
`ifdef SRS_RX_PARITY_EN
                    shreg_d = shift_nxt;
                    par_d   = par_q ^ sdin;
`else
                    shreg_d = shift_nxt[SW-1:0];
`endif
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (!rts) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef SRS_RX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
`ifdef SRS_RX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign ack    = (state_q != IDLE);
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_srs_receiver_fsm.sv
// Directed bench for srs_receiver_fsm with a word scoreboard.
// Inputs change 1 time unit after the rising edge; the output buffer and
// err are watched on the falling edge.

module tb_srs_receiver_fsm;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         rts;
    logic         sclk;
    logic         sdin;
    logic         rready;
    logic         ack;
    logic [W-1:0] rdata;
    logic         rvalid;
    logic         err;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int err_exp = 0;
    logic [31:0] sb_q[$];

    srs_receiver_fsm #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .rts    (rts),
        .sclk   (sclk),
        .sdin   (sdin),
        .rready (rready),
        .ack    (ack),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every word leaving the buffer must match the oldest expected word.
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (rst === 1'b1) begin
            if (err === 1'b1) err_cnt++;
            if (rvalid === 1'b1 && rready === 1'b1) begin
                chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_w = sb_q.pop_front();
                    chk("sb_word", 32'(rdata), exp_w);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        sdin = b;
        sclk = 1'b1;
        step();
        sclk = 1'b0;
        sdin = 1'b0;
        step();
    endtask

    task automatic grant();
        rts = 1'b1;
        step();
        chk("ack_rise", 32'(ack), 32'd1);
    endtask

    task automatic release_rts();
        rts = 1'b0;
        step();
        chk("ack_fall", 32'(ack), 32'd0);
    endtask

    // Sends the data bits MSB first; rts_end is rts during the final strobe.
    task automatic send_data(input logic [31:0] word, input logic rts_end);
        logic [W-1:0] w;
        w = word[W-1:0];
        for (int i = W - 1; i >= 1; i--) strobe(w[i]);
`ifdef SRS_RX_PARITY_EN
        strobe(w[0]);
        sdin = ^w;
`else
        sdin = w[0];
`endif
        sclk = 1'b1;
        rts  = rts_end;
        step();
        sclk = 1'b0;
        sdin = 1'b0;
        chk("rvalid_latency", 32'(rvalid), 32'd1);
        chk("rdata_latency", 32'(rdata), word);
        chk("no_err", 32'(err), 32'd0);
    endtask

    task automatic full_frame(input logic [31:0] word);
        grant();
        sb_q.push_back(word);
        send_data(word, 1'b1);
        step();
        chk("done_ack_held", 32'(ack), 32'd1);
        release_rts();
    endtask

    initial begin
        rst    = 1'b0;
        rts    = 1'b0;
        sclk   = 1'b0;
        sdin   = 1'b0;
        rready = 1'b1;
        step();
        step();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        step();

        // Basic frame
        full_frame(32'hA5);

        // Back-pressure: buffer full and rready low holds ack low
        rready = 1'b0;
        full_frame(32'h3C);
        rts = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_ack_low", 32'(ack), 32'd0);
        end
        chk("bp_rvalid_held", 32'(rvalid), 32'd1);
        chk("bp_rdata_held", 32'(rdata), 32'h3C);
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("bp_ack_rise", 32'(ack), 32'd1);
        chk("bp_popped", 32'(rvalid), 32'd0);
        sb_q.push_back(32'hC3);
        send_data(32'hC3, 1'b1);
        step();
        chk("bp_word_held", 32'(rvalid), 32'd1);
        rready = 1'b1;
        step();
        chk("bp_word_popped", 32'(rvalid), 32'd0);
        release_rts();

        // Abort after 3 strobes
        grant();
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b0);
        rts = 1'b0;
        step();
        err_exp++;
        chk("abort_err", 32'(err), 32'd1);
        chk("abort_ack", 32'(ack), 32'd0);
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        step();
        chk("abort_err_one_cycle", 32'(err), 32'd0);
        full_frame(32'h5A);

        // Reset mid-frame
        grant();
        for (int i = 0; i < 5; i++) strobe(1'b1);
        #2;
        rst = 1'b0;
        rts = 1'b0;
        #1;
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_rvalid", 32'(rvalid), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        step();
        rst = 1'b1;
        step();
        full_frame(32'hFF);

        // Stray strobes in IDLE and DONE
        sclk = 1'b1;
        sdin = 1'b1;
        for (int i = 0; i < 3; i++) step();
        sclk = 1'b0;
        sdin = 1'b0;
        chk("stray_idle_ack", 32'(ack), 32'd0);
        chk("stray_idle_rvalid", 32'(rvalid), 32'd0);
        grant();
        sb_q.push_back(32'h81);
        send_data(32'h81, 1'b1);
        sclk = 1'b1;
        sdin = 1'b1;
        for (int i = 0; i < 3; i++) step();
        sclk = 1'b0;
        sdin = 1'b0;
        step();
        chk("stray_done_ack", 32'(ack), 32'd1);
        chk("stray_done_rvalid", 32'(rvalid), 32'd0);
        chk("stray_done_rdata", 32'(rdata), 32'h81);
        release_rts();
        full_frame(32'h42);

        // rts drops together with the final strobe: frame completes, straight to IDLE
        grant();
        sb_q.push_back(32'h96);
        send_data(32'h96, 1'b0);
        chk("lastdrop_ack", 32'(ack), 32'd0);
        step();
        chk("lastdrop_ack_idle", 32'(ack), 32'd0);
        chk("lastdrop_err", 32'(err), 32'd0);

`ifdef SRS_RX_PARITY_EN
        // Good parity
        full_frame(32'h07);
        // Bad parity: err, nothing buffered, ack held until rts low
        grant();
        for (int i = W - 1; i >= 0; i--) strobe(((32'h07 >> i) & 32'd1) != 0);
        sdin = 1'b0;
        sclk = 1'b1;
        step();
        sclk = 1'b0;
        err_exp++;
        chk("par_err", 32'(err), 32'd1);
        chk("par_rvalid", 32'(rvalid), 32'd0);
        chk("par_ack_held", 32'(ack), 32'd1);
        step();
        chk("par_err_one_cycle", 32'(err), 32'd0);
        chk("par_ack_still", 32'(ack), 32'd1);
        chk("par_rdata_kept", 32'(rdata), 32'h07);
        release_rts();
`endif

        step();
        step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("err_pulse_count", 32'(err_cnt), 32'(err_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
